// File: rtl/drum_mem_unit.sv
// Rotating-drum word memory: a free-running sector/phase counter sweeps the drum,
// and each accepted read or write completes when its sector's last phase passes the head.
module drum_mem_unit #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 31,
    parameter int SECTOR_CYCLES = 4   // must be at least 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_read_from_pu,
    input  logic                  mem_write_from_ac,
    input  logic [ADDR_WIDTH-1:0] addr_from_sel,
    input  logic [DATA_WIDTH-1:0] data_from_ac,
    output logic                  mem_reply_to_pu,
    output logic [DATA_WIDTH-1:0] mem_data_to_ac,
    output logic                  write_done_to_ac,
    output logic                  mem_busy,
    output logic                  overrun_err,
    output logic [ADDR_WIDTH-1:0] sector_pos
);

    localparam int                PHASE_W    = (SECTOR_CYCLES > 1) ? $clog2(SECTOR_CYCLES) : 1;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SECTOR_CYCLES - 1);
    localparam int                DEPTH      = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REPLY
    } state_t;

    state_t                  state_q, state_d;
    logic [PHASE_W-1:0]      phase_q;
    logic [ADDR_WIDTH-1:0]   sector_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    op_read_q;
    logic                    overrun_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic sector_end;
    logic fire;
    logic accept;
    logic dropped;

    assign sector_end = (phase_q == LAST_PHASE);
    assign fire       = (state_q == S_WAIT) && sector_end && (sector_q == addr_q);
    assign accept     = (state_q == S_IDLE) && (mem_read_from_pu || mem_write_from_ac);
    // In IDLE only a read/write collision loses a request; otherwise any pulse is lost.
    assign dropped    = (state_q == S_IDLE) ? (mem_read_from_pu && mem_write_from_ac)
                                            : (mem_read_from_pu || mem_write_from_ac);

    // The drum never stops: position advances every cycle regardless of traffic.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_q  <= '0;
            sector_q <= '0;
        end else if (sector_end) begin
            phase_q  <= '0;
            sector_q <= sector_q + 1'b1;
        end else begin
            phase_q  <= phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d          = state_q;
        mem_busy         = 1'b0;
        mem_reply_to_pu  = 1'b0;
        write_done_to_ac = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_WAIT;
            end
            S_WAIT: begin
                mem_busy = 1'b1;
                if (fire) state_d = S_REPLY;
            end
            S_REPLY: begin
                mem_busy         = 1'b1;
                mem_reply_to_pu  = op_read_q;
                write_done_to_ac = !op_read_q;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            op_read_q <= 1'b0;
            overrun_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                addr_q    <= addr_from_sel;
                op_read_q <= mem_read_from_pu;
                if (!mem_read_from_pu) wdata_q <= data_from_ac;
            end
            if (dropped) overrun_q <= 1'b1;
            if (fire && op_read_q) rdata_q <= mem[addr_q];
        end
    end

    // NOTE: the storage array has no reset; contents survive resetn, and a reset
    // during WAIT forces state_q to IDLE so the pending write can never land.
    always_ff @(posedge clk) begin
        if (fire && !op_read_q) mem[addr_q] <= wdata_q;
    end

    assign mem_data_to_ac = rdata_q;
    assign overrun_err    = overrun_q;
    assign sector_pos     = sector_q;

endmodule

// File: tb/tb_drum_mem_unit.sv
// Bench for drum_mem_unit: directed scenarios plus random traffic, scored against
// an arithmetic model of drum position and a queue of expected replies.
module tb_drum_mem_unit;

    localparam int AW  = 3;
    localparam int DW  = 31;
    localparam int SC  = 4;
    localparam int NW  = 1 << AW;
    localparam int REV = NW * SC;
    localparam int BIG = 1 << 30;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          reply;
    logic [DW-1:0] rdata;
    logic          done;
    logic          busy;
    logic          overrun;
    logic [AW-1:0] sector_pos;

    drum_mem_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SECTOR_CYCLES(SC)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .mem_read_from_pu (rd),
        .mem_write_from_ac(wr),
        .addr_from_sel    (addr),
        .data_from_ac     (wdata),
        .mem_reply_to_pu  (reply),
        .mem_data_to_ac   (rdata),
        .write_done_to_ac (done),
        .mem_busy         (busy),
        .overrun_err      (overrun),
        .sector_pos       (sector_pos)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release: cycle 0 is the interval before the first edge.
    int cyc;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        bit            is_read;
        int            a;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] model_mem [NW];
    logic [DW-1:0] model_last = '0;
    int            busy_lo = 0;
    int            busy_hi = -1;
    int            ovr_from = BIG;
    int            last_reply_cyc = -1;
    int            n_checks = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A request at cycle c completes at the first later cycle whose drum position is
    // the last phase of sector a; the reply appears one cycle after that.
    function automatic int reply_cycle(input int c, input int a);
        int t;
        t = c - (c % REV) + a * SC + SC - 1;
        if (t <= c) t += REV;
        return t + 1;
    endfunction

    always @(negedge clk) begin
        if (resetn) begin
            check("sector_pos", 64'(sector_pos), 64'((cyc / SC) % NW));
            if (sb.size() > 0 && sb[0].cyc < cyc && !(reply || done)) begin
                check("reply_missing_at", 64'(cyc), 64'(sb[0].cyc));
                void'(sb.pop_front());
            end
            if (reply || done) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 64'({reply, done}), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_kind", 64'({reply, done}), mon_e.is_read ? 64'h2 : 64'h1);
                    check("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
                    if (mon_e.is_read) model_last = mon_e.data;
                    else               model_mem[mon_e.a] = mon_e.data;
                    last_reply_cyc = cyc;
                end
            end
            check("mem_busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
            check("mem_data", 64'(rdata), 64'(model_last));
            check("overrun_err", 64'(overrun), 64'(cyc >= ovr_from));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic wait_idle();
        while (cyc <= busy_hi) step();
    endtask

    task automatic apply_reset();
        rd = 1'b0;
        wr = 1'b0;
        resetn = 1'b0;
        sb.delete();
        busy_lo = 0;
        busy_hi = -1;
        ovr_from = BIG;
        model_last = '0;
        #1;
        check("rst_reply", 64'(reply), 64'(0));
        check("rst_data", 64'(rdata), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check("rst_sector", 64'(sector_pos), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic issue(input bit r, input bit w, input int a, input logic [DW-1:0] d);
        int   c;
        exp_t e;
        c     = cyc;
        rd    = r;
        wr    = w;
        addr  = a[AW-1:0];
        wdata = d;
        if (r || w) begin
            if (c > busy_hi) begin
                e.is_read = r;
                e.a       = a;
                e.data    = r ? model_mem[a] : d;
                e.cyc     = reply_cycle(c, a);
                sb.push_back(e);
                busy_lo = c + 1;
                busy_hi = e.cyc;
                if (r && w && ovr_from > c + 1) ovr_from = c + 1;
            end else if (ovr_from > c + 1) begin
                ovr_from = c + 1;
            end
        end
        step();
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 4 * REV) begin
            step();
            n++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
            busy_hi = -1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();

        // Give every word a known value; the array keeps it across later resets.
        for (int i = 0; i < NW; i++) begin
            wait_idle();
            issue(1'b0, 1'b1, i, DW'($urandom));
        end
        drain();

        // Write at cycle 0, then read back after it has to wait a full revolution.
        apply_reset();
        issue(1'b0, 1'b1, 2, 31'h12345);
        drain();
        check("write_done_cycle", 64'(last_reply_cyc), 64'(12));
        wait_cyc(13);
        issue(1'b1, 1'b0, 2, '0);
        drain();
        check("readback_cycle", 64'(last_reply_cyc), 64'(44));
        check("readback_data", 64'(rdata), 64'(31'h12345));

        // Same-sector read caught in this pass versus issued on the firing cycle.
        apply_reset();
        wait_cyc(9);
        issue(1'b1, 1'b0, 2, '0);
        drain();
        check("same_pass_cycle", 64'(last_reply_cyc), 64'(12));
        apply_reset();
        wait_cyc(11);
        issue(1'b1, 1'b0, 2, '0);
        drain();
        check("missed_sector_cycle", 64'(last_reply_cyc), 64'(44));

        // Second read while busy is ignored and flags overrun.
        apply_reset();
        issue(1'b1, 1'b0, 7, '0);
        wait_cyc(5);
        issue(1'b1, 1'b0, 3, '0);
        drain();
        check("busy_first_reply", 64'(last_reply_cyc), 64'(32));
        check("busy_overrun", 64'(overrun), 64'(1));

        // Read/write collision in IDLE: only the read completes.
        apply_reset();
        issue(1'b1, 1'b1, 1, 31'h55AA55);
        drain();
        check("collision_overrun", 64'(overrun), 64'(1));
        wait_idle();
        issue(1'b1, 1'b0, 4, '0);
        issue(1'b0, 1'b0, 0, '0);
        drain();

        // Reset in the middle of a pending write: nothing lands, nothing replies.
        apply_reset();
        issue(1'b0, 1'b1, 5, 31'h7);
        wait_cyc(10);
        check("pre_reset_busy", 64'(busy), 64'(1));
        apply_reset();
        wait_cyc(40);
        issue(1'b1, 1'b0, 5, '0);
        drain();

        // Sector wrap 7 -> 0 at cycle 32.
        apply_reset();
        wait_cyc(30);
        issue(1'b1, 1'b0, 0, '0);
        drain();
        check("wrap_reply_cycle", 64'(last_reply_cyc), 64'(36));

        // Random traffic, including requests that arrive while busy.
        apply_reset();
        for (int k = 0; k < 60; k++) begin
            int sel;
            repeat ($urandom_range(0, 40)) step();
            sel = $urandom_range(0, 9);
            issue(sel <= 4 || sel == 9, sel >= 5, $urandom_range(0, NW - 1), DW'($urandom));
        end
        drain();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/drum_mem_unit.md
Name: drum_mem_unit

Overview:
- Responder end of the memory read handshake.
- Accepts single-cycle read pulses from the pulse distributor and write pulses from arithmetic control.
- Models a rotating magnetic drum: one word per angular sector, with a free-running sector position counter.
- Completes each access only when the addressed sector passes the head, then returns a one-cycle reply/done pulse. Access latency is therefore position-dependent but deterministic.

Parameters:
- ADDR_WIDTH, 10: word address width; drum holds 2^ADDR_WIDTH sectors/words.
- DATA_WIDTH, 31: word width.
- SECTOR_CYCLES, 4: clock cycles per sector (must be at least 2).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mem_read_from_pu  in  1  pulse: read request
- mem_write_from_ac  in  1  pulse: write request
- addr_from_sel  in  ADDR_WIDTH  address from select register, sampled on accept
- data_from_ac  in  DATA_WIDTH  write data, sampled on accept
- mem_reply_to_pu  out  1  pulse: read data valid
- mem_data_to_ac  out  DATA_WIDTH  level: last read word
- write_done_to_ac  out  1  pulse: write committed
- mem_busy  out  1  level: request outstanding
- overrun_err  out  1  sticky: request dropped
- sector_pos  out  ADDR_WIDTH  current head sector (debug)

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is asynchronous and active-low on resetn.
  - Reset clears all state, counters and outputs.
  - Memory array is not cleared; simulation initialises it to 0.
- Outputs during reset: mem_reply_to_pu=0, mem_data_to_ac=0, write_done_to_ac=0, mem_busy=0, overrun_err=0, sector_pos=0.
- Drum position:
  - phase counter runs 0..SECTOR_CYCLES-1, incrementing every cycle. It is never stalled by requests.
  - When phase==SECTOR_CYCLES-1, phase wraps to 0 and sector_pos increments modulo 2^ADDR_WIDTH.
  - First cycle after reset release: sector 0, phase 0.
- State machine (IDLE, WAIT, REPLY):
  - IDLE:
    - Read pulse: latch addr and op=read, go to WAIT.
    - Write pulse only: latch addr, data and op=write, go to WAIT.
    - Read and write in the same cycle: read is accepted, the write is dropped, overrun_err is set.
  - WAIT:
    - mem_busy=1.
    - The access fires on the cycle where sector_pos==latched addr and phase==SECTOR_CYCLES-1.
    - Read access: array word goes to mem_data_to_ac register.
    - Write access: data is written to the array.
    - Then go to REPLY.
  - REPLY:
    - Exactly one cycle.
    - mem_reply_to_pu=1 for a read, or write_done_to_ac=1 for a write.
    - mem_busy=1.
    - Returns to IDLE next cycle.
- Same-pass access: a request accepted in IDLE earlier within the target sector still fires at that sector's last phase in the same pass.
- Missed sector: a request accepted on the firing cycle itself, or later, waits a full revolution.
- Latency: accept-to-reply is 2 to 2^ADDR_WIDTH*SECTOR_CYCLES+1 cycles.
- Requests while in WAIT or REPLY:
  - Ignored; the latched request is unaffected.
  - overrun_err is set.
  - overrun_err clears only on reset.
- mem_data_to_ac holds its value until the next read access. Writes never change it.
- Write then read of the same address: the read returns the new data.
- Reset asserted mid-access: the pending access is abandoned, no array write occurs, and no reply is issued after release.

Test Plan (ADDR_WIDTH=3, SECTOR_CYCLES=4; cycle 0 = first cycle after reset release):
- Write: write pulse at cycle 0, addr=2, data=0x12345 -> array write at cycle 11; write_done_to_ac high in cycle 12 only; mem_busy high cycles 1-12.
- Read-back with full revolution: read pulse at cycle 13, addr=2 -> mem_reply_to_pu high in cycle 44 only; mem_data_to_ac=0x12345 from cycle 44 onward.
- Same-sector request: read at cycle 9 (sector 2, phase 1), addr=2 -> reply at cycle 12. Same read issued at cycle 11 -> reply at cycle 44.
- Busy overrun and collision: second read at cycle 5 while the first (issued at cycle 0, addr=7) is pending -> ignored, overrun_err=1, first reply at cycle 32. In a separate run, simultaneous read/write at IDLE -> only the read completes; overrun_err=1; the write address keeps its old data.
- Async reset mid-operation: write addr=5, data=0x7 issued; resetn pulled low at cycle 10 mid-wait -> outputs 0 immediately; no write_done after release; later read of addr 5 returns the prior value.
- Wrap-around: sector_pos sequence 7 -> 0 at cycle 32; read addr=0 issued at cycle 30 -> reply at cycle 36.
